// File: rtl/router_pkg.sv
// Shared types and address constants for the router control FSM.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;

  localparam logic [1:0] R0 = 2'b00;
  localparam logic [1:0] R1 = 2'b01;
  localparam logic [1:0] R2 = 2'b10;

  // Address 3 selects nothing, so it reads as 0.
  function automatic logic pick3(
    input logic [1:0] a,
    input logic [2:0] v
  );
    logic r;
    r = 1'b0;
    case (a)
      R0:      r = v[0];
      R1:      r = v[1];
      R2:      r = v[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/router_ctrl_port_sel.sv
// Destination address latch and per-port flag selection.
module router_ctrl_port_sel
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       latch_en,
  input  logic [1:0] data_in,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic [1:0] addr_q,
  output logic       addr_ok,
  output logic       empty_in,
  output logic       empty_addr,
  output logic       srst_addr
);

  logic [1:0] addr_d;
  logic [2:0] empties;
  logic [2:0] srsts;

  assign empties = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign srsts   = {soft_reset_2, soft_reset_1, soft_reset_0};

  always_comb begin
    addr_d = addr_q;
    if (latch_en) addr_d = data_in;
  end

  always_ff @(posedge clock) begin
    if (!resetn) addr_q <= R0;
    else         addr_q <= addr_d;
  end

  assign addr_ok    = (data_in != 2'b11);
  assign empty_in   = pick3(data_in, empties);
  assign empty_addr = pick3(addr_q, empties);
  assign srst_addr  = pick3(addr_q, srsts);

endmodule

// File: rtl/router_ctrl_fsm.sv
// Router packet-control Moore FSM.
// Optional completed-packet counter: define ROUTER_CTRL_PKT_COUNT_EN.
module router_ctrl_fsm
  import router_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             pkt_valid,
  input  logic [1:0]       data_in,
  input  logic             fifo_full,
  input  logic             fifo_empty_0,
  input  logic             fifo_empty_1,
  input  logic             fifo_empty_2,
  input  logic             soft_reset_0,
  input  logic             soft_reset_1,
  input  logic             soft_reset_2,
  input  logic             parity_done,
  input  logic             low_pkt_valid,
  output logic             detect_add,
  output logic             lfd_state,
  output logic             ld_state,
  output logic             laf_state,
  output logic             full_state,
  output logic             rst_int_reg,
  output logic             write_enb_reg,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count
);

  state_e     state_q;
  state_e     state_d;
  logic [1:0] addr_q;
  logic       addr_ok;
  logic       empty_in;
  logic       empty_addr;
  logic       srst_addr;
  logic       latch_en;

  assign latch_en = (state_q == DECODE_ADDRESS) && pkt_valid;

  router_ctrl_port_sel u_sel (
    .clock        (clock),
    .resetn       (resetn),
    .latch_en     (latch_en),
    .data_in      (data_in),
    .fifo_empty_0 (fifo_empty_0),
    .fifo_empty_1 (fifo_empty_1),
    .fifo_empty_2 (fifo_empty_2),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2),
    .addr_q       (addr_q),
    .addr_ok      (addr_ok),
    .empty_in     (empty_in),
    .empty_addr   (empty_addr),
    .srst_addr    (srst_addr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && addr_ok)
          state_d = empty_in ? LOAD_FIRST_DATA
                             : WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_d = fifo_full ? FIFO_FULL_STATE
                            : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (empty_addr) state_d = LOAD_FIRST_DATA;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    // Addressed port's read timeout aborts the packet.
    if (state_q != DECODE_ADDRESS && srst_addr)
      state_d = DECODE_ADDRESS;
  end

  always_ff @(posedge clock) begin
    if (!resetn) state_q <= DECODE_ADDRESS;
    else         state_q <= state_d;
  end

  assign detect_add  = (state_q == DECODE_ADDRESS);
  assign lfd_state   = (state_q == LOAD_FIRST_DATA);
  assign ld_state    = (state_q == LOAD_DATA);
  assign laf_state   = (state_q == LOAD_AFTER_FULL);
  assign full_state  = (state_q == FIFO_FULL_STATE);
  assign rst_int_reg = (state_q == CHECK_PARITY_ERROR);

  assign write_enb_reg = (state_q == LOAD_DATA)
                       | (state_q == LOAD_PARITY)
                       | (state_q == LOAD_AFTER_FULL);

  assign busy = (state_q != DECODE_ADDRESS)
             && (state_q != LOAD_DATA);

`ifdef ROUTER_CTRL_PKT_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pkt_done;

  always_comb begin
    pkt_done = 1'b0;
    if (!srst_addr) begin
      if (state_q == CHECK_PARITY_ERROR && !fifo_full)
        pkt_done = 1'b1;
      if (state_q == LOAD_AFTER_FULL && parity_done)
        pkt_done = 1'b1;
    end
    cnt_d = cnt_q;
    if (pkt_done)
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clock) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign pkt_count = cnt_q;
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Scoreboard bench for router_ctrl_fsm: directed cycles, queued expectations.
module tb_router_ctrl_fsm;

  localparam int S_DA  = 0;
  localparam int S_LFD = 1;
  localparam int S_LD  = 2;
  localparam int S_FFS = 3;
  localparam int S_LAF = 4;
  localparam int S_LP  = 5;
  localparam int S_CPE = 6;
  localparam int S_WTE = 7;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done, low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, write_enb_reg, busy;
  logic [7:0] pkt_count;

  typedef struct packed {
    logic [7:0] outs;
    logic [7:0] cnt;
    logic [7:0] tag;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [7:0] cur_tag = 8'd0;

  router_ctrl_fsm #(.CNT_W(8)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .write_enb_reg (write_enb_reg),
    .busy          (busy),
    .pkt_count     (pkt_count)
  );

  always #5 clock = ~clock;

  // {detect_add,lfd,ld,laf,full,rst_int,write_enb,busy}
  function automatic logic [7:0] outs_of(input int s);
    case (s)
      S_DA:    return 8'b1000_0000;
      S_LFD:   return 8'b0100_0001;
      S_LD:    return 8'b0010_0010;
      S_FFS:   return 8'b0000_1001;
      S_LAF:   return 8'b0001_0011;
      S_LP:    return 8'b0000_0011;
      S_CPE:   return 8'b0000_0101;
      default: return 8'b0000_0001;
    endcase
  endfunction

  task automatic bump();
`ifdef ROUTER_CTRL_PKT_COUNT_EN
    exp_cnt = exp_cnt + 8'd1;
`endif
  endtask

  // Apply current inputs across one edge; queue the post-edge expectation.
  task automatic cyc(input int s);
    exp_t e;
    @(posedge clock);
    e.outs = outs_of(s);
    e.cnt  = exp_cnt;
    e.tag  = cur_tag;
    sb_q.push_back(e);
    #1;
  endtask

  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = sb_q.pop_front();
      act = {detect_add, lfd_state, ld_state, laf_state,
             full_state, rst_int_reg, write_enb_reg, busy};
      total++;
      if (act !== e.outs || pkt_count !== e.cnt) begin
        bad++;
        $display("FAIL step%0d t=%0t outs=%b cnt=%0d want outs=%b cnt=%0d",
                 e.tag, $time, act, pkt_count, e.outs, e.cnt);
      end
    end
  end

  task automatic idle_inputs();
    pkt_valid = 0; data_in = 0; fifo_full = 0;
    fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
    parity_done = 0; low_pkt_valid = 0;
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    #1;
    // reset
    cur_tag = 1;
    cyc(S_DA); cyc(S_DA);
    resetn = 1;

    // addr 1 into LOAD_DATA
    cur_tag = 2;
    data_in = 1; pkt_valid = 1;
    cyc(S_LFD); cyc(S_LD); cyc(S_LD);

    // full for 3 cycles, then LAF -> LP -> CPE -> DA
    cur_tag = 3;
    fifo_full = 1;
    cyc(S_FFS); cyc(S_FFS); cyc(S_FFS);
    fifo_full = 0;
    cyc(S_LAF);
    low_pkt_valid = 1;
    cyc(S_LP);
    low_pkt_valid = 0; pkt_valid = 0;
    cyc(S_CPE);
    bump(); cyc(S_DA);

    // busy destination 2: wait 5 cycles
    cur_tag = 4;
    data_in = 2; pkt_valid = 1; fifo_empty_2 = 0;
    cyc(S_WTE);
    pkt_valid = 0; data_in = 0;
    repeat (4) cyc(S_WTE);
    fifo_empty_2 = 1;
    cyc(S_LFD); cyc(S_LD); cyc(S_LP); cyc(S_CPE);
    // CPE with full -> FFS, then LAF exits with parity_done
    fifo_full = 1;
    cyc(S_FFS);
    fifo_full = 0;
    cyc(S_LAF);
    parity_done = 1;
    bump(); cyc(S_DA);
    parity_done = 0;

    // soft resets: only the addressed port matters
    cur_tag = 5;
    data_in = 0; pkt_valid = 1;
    cyc(S_LFD); cyc(S_LD);
    soft_reset_1 = 1;
    cyc(S_LD);
    soft_reset_1 = 0; soft_reset_0 = 1;
    cyc(S_DA);
    // ignored while in DECODE_ADDRESS, active next state
    pkt_valid = 0;
    cyc(S_DA);
    pkt_valid = 1;
    cyc(S_LFD);
    cyc(S_DA);
    soft_reset_0 = 0;

    // invalid address 3 dropped
    cur_tag = 6;
    data_in = 3; pkt_valid = 1;
    cyc(S_DA); cyc(S_DA);
    soft_reset_2 = 1;
    cyc(S_DA);
    soft_reset_2 = 0;

    // fifo_full beats pkt_valid=0 in LOAD_DATA; LAF back to LD
    cur_tag = 7;
    data_in = 1; pkt_valid = 1;
    cyc(S_LFD);
    pkt_valid = 0;
    cyc(S_LD);
    fifo_full = 1;
    cyc(S_FFS);
    fifo_full = 0;
    cyc(S_LAF);
    pkt_valid = 1;
    cyc(S_LD);
    pkt_valid = 0;
    cyc(S_LP); cyc(S_CPE);
    bump(); cyc(S_DA);

    // reset then 257 packets -> count wraps to 1
    cur_tag = 8;
    resetn = 0; exp_cnt = 0;
    cyc(S_DA);
    resetn = 1;
    for (int i = 0; i < 257; i++) begin
      data_in = 0; pkt_valid = 1;
      cyc(S_LFD);
      pkt_valid = 0;
      cyc(S_LD); cyc(S_LP); cyc(S_CPE);
      bump(); cyc(S_DA);
    end

    // reset mid-packet abandons it
    cur_tag = 9;
    data_in = 2; pkt_valid = 1;
    cyc(S_LFD); cyc(S_LD);
    resetn = 0; exp_cnt = 0;
    cyc(S_DA);
    resetn = 1; pkt_valid = 0;
    cyc(S_DA); cyc(S_DA);

    repeat (3) @(negedge clock);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_ctrl_fsm.md
ROUTER_CTRL_FSM -- requirements
Module: router_ctrl_fsm

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the completed-packet counter.
REQ-002 SHALL have port clock, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port pkt_valid, input, 1: a packet byte is present on the source side.
REQ-005 SHALL have port data_in, input, 2: destination address, header bits [1:0]; 0/1/2 are valid, 3 is invalid.
REQ-006 SHALL have ports fifo_full, input, 1: full flag of the currently addressed FIFO, from the synchronizer.
REQ-007 SHALL have ports fifo_empty_0/1/2, input, 1 each: per-port FIFO empty flags.
REQ-008 SHALL have ports soft_reset_0/1/2, input, 1 each: per-port read-timeout soft resets.
REQ-009 SHALL have ports parity_done and low_pkt_valid, input, 1 each: status flags from the register block.
REQ-010 SHALL have ports detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy, output, 1 each.
REQ-011 SHALL have port pkt_count, output, CNT_W: count of completed packets.

Function
REQ-012 SHALL implement a Moore FSM with 8 states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
REQ-013 SHALL latch data_in into an internal addr_q in DECODE_ADDRESS when pkt_valid=1; addr_q holds in all other states.
REQ-014 In DECODE_ADDRESS, SHALL go to LOAD_FIRST_DATA when pkt_valid=1, data_in<3 and fifo_empty_<data_in>=1.
- Goes to WAIT_TILL_EMPTY when pkt_valid=1, data_in<3 and fifo_empty_<data_in>=0.
- Otherwise stays in DECODE_ADDRESS; data_in=3 is dropped.
REQ-015 LOAD_FIRST_DATA SHALL go unconditionally to LOAD_DATA after 1 cycle.
REQ-016 LOAD_DATA SHALL go to FIFO_FULL_STATE when fifo_full=1.
- Else goes to LOAD_PARITY when pkt_valid=0.
- Else stays; fifo_full has priority over pkt_valid.
REQ-017 FIFO_FULL_STATE SHALL stay while fifo_full=1 and go to LOAD_AFTER_FULL when fifo_full=0.
REQ-018 LOAD_AFTER_FULL SHALL go to DECODE_ADDRESS when parity_done=1.
- Else goes to LOAD_PARITY when low_pkt_valid=1.
- Else goes to LOAD_DATA.
REQ-019 LOAD_PARITY SHALL go unconditionally to CHECK_PARITY_ERROR.
REQ-020 CHECK_PARITY_ERROR SHALL go to FIFO_FULL_STATE when fifo_full=1, else to DECODE_ADDRESS.
REQ-021 WAIT_TILL_EMPTY SHALL go to LOAD_FIRST_DATA when fifo_empty_<addr_q>=1, else stay.
REQ-022 SHALL force the next state to DECODE_ADDRESS when soft_reset_<addr_q>=1.
- Priority: below resetn, above all other transitions.
- Applies in every state except DECODE_ADDRESS.
- Soft resets of non-addressed ports are ignored.
REQ-023 SHALL decode outputs from the current state only.
- detect_add=DECODE_ADDRESS
- lfd_state=LOAD_FIRST_DATA
- ld_state=LOAD_DATA
- laf_state=LOAD_AFTER_FULL
- full_state=FIFO_FULL_STATE
- rst_int_reg=CHECK_PARITY_ERROR
- write_enb_reg=LOAD_DATA|LOAD_PARITY|LOAD_AFTER_FULL
- busy=1 in every state except DECODE_ADDRESS and LOAD_DATA
REQ-024 Exactly one of detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg SHALL be 1 in any state except LOAD_PARITY and WAIT_TILL_EMPTY, where all six are 0.

Reset
REQ-025 When resetn=0 at a rising edge, SHALL set state=DECODE_ADDRESS, addr_q=0 and pkt_count=0.
- Resulting outputs: detect_add=1, all other 1-bit outputs=0.
REQ-026 Reset mid-packet SHALL abandon the packet with no further write_enb_reg assertion.

Configuration
REQ-027 Macro ROUTER_CTRL_PKT_COUNT_EN, when defined: pkt_count SHALL increment by 1 on each CHECK_PARITY_ERROR->DECODE_ADDRESS transition.
- Also increments on each LOAD_AFTER_FULL->DECODE_ADDRESS transition with parity_done=1.
- Wraps modulo 2^CNT_W.
- Is not incremented by a soft-reset exit.
REQ-028 Without the macro, pkt_count SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-029 Package router_pkg SHALL hold the state enum/encoding and the port address constants R0=2'b00, R1=2'b01, R2=2'b10.
REQ-030 Sub-module router_ctrl_port_sel SHALL hold the address latch and select fifo_empty/soft_reset per data_in/addr_q; the FSM stays in the top.

Verification
REQ-031 Idle, data_in=1, pkt_valid=1, fifo_empty_1=1 -> lfd_state next cycle, then ld_state with write_enb_reg=1; busy=1 only in LOAD_FIRST_DATA.
REQ-032 LOAD_DATA with fifo_full=1 for 3 cycles -> full_state=1 for 3 cycles, then laf_state=1.
- Then low_pkt_valid=1, parity_done=0 -> LOAD_PARITY, then rst_int_reg=1.
REQ-033 data_in=2, fifo_empty_2=0 for 5 cycles -> WAIT_TILL_EMPTY for 5 cycles, write_enb_reg=0 throughout; fifo_empty_2=1 -> lfd_state.
REQ-034 addr_q=0 in LOAD_DATA, soft_reset_1=1 -> no effect.
- soft_reset_0=1 -> detect_add=1 next cycle; pkt_count unchanged.
REQ-035 data_in=3 with pkt_valid=1 -> remains in DECODE_ADDRESS, write_enb_reg=0.
REQ-036 With macro defined, CNT_W=8: 257 complete packets -> pkt_count=1.
- resetn=0 mid-packet -> pkt_count=0 and detect_add=1 after the edge.
